pll_reconfig_sequencer: RTL and testbench

- Avalon-MM master that drives the reconfigurable-PLL peripheral's slave port from a single (n, m, c0) command.
- Per divider, derives high/low/bypass/odd counts and issues 12 parameter writes, then a trigger write.
- Polls busy status, then waits for the reconfigured clock domain to come out of reset.
- Sits between a software/boot controller and the PLL peripheral; frequency changes need no CPU bit-banging.

---
 rtl/pll_reconfig_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_pll_reconfig_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_sequencer.sv
// rtl/pll_reconfig_sequencer.sv - Avalon-MM sequencer that programs PLL n/m/c0 dividers and waits for lock
// Optional readback check of all divider parameters: define RECONFIG_SEQ_VERIFY_EN.
module pll_reconfig_sequencer #(
  parameter int SETTLE_CYCLES     = 4,
  parameter int POLL_TIMEOUT      = 65535,
  parameter int READY_SYNC_STAGES = 2
) (
  input  logic        csi_clk_clock,
  input  logic        csi_clk_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_n,
  input  logic [8:0]  cmd_m,
  input  logic [8:0]  cmd_c0,
  output logic        done,
  output logic        error,
  output logic [7:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        pll_ready_n_async
);

  localparam logic [7:0]  STATUS_ADDR  = 8'h80;
  localparam logic [3:0]  LAST_IDX     = 4'd11;
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(POLL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GO,
    S_SETTLE,
    S_POLL,
    S_WAIT_LOCK,
    S_DONE
`ifdef RECONFIG_SEQ_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [8:0]  n_q, m_q, c0_q;
  logic [15:0] settle_cnt;
  logic [31:0] tcnt;
  logic [READY_SYNC_STAGES-1:0] ready_sync;
  logic        pll_ready_n;
  logic [7:0]  next_addr;
  logic [31:0] next_data;

  // Entries 0..3 belong to n, 4..7 to m, 8..11 to c0.
  function automatic logic [8:0] pick_value(input logic [3:0] i, input logic [8:0] n,
                                            input logic [8:0] m, input logic [8:0] c0);
    if (i < 4'd4)      return n;
    else if (i < 4'd8) return m;
    else               return c0;
  endfunction

  // Parameter value for entry i: high, low, bypass, odd in that order per divider.
  function automatic logic [31:0] entry_data(input logic [3:0] i, input logic [8:0] n,
                                             input logic [8:0] m, input logic [8:0] c0);
    logic [8:0] v;
    logic [9:0] sum;
    logic [8:0] high;
    v    = pick_value(i, n, m, c0);
    sum  = {1'b0, v} + 10'd1;
    high = sum[9:1];
    case (i[1:0])
      2'd0:    return {23'd0, high};
      2'd1:    return {23'd0, v - high};
      2'd2:    return {31'd0, v == 9'd1};
      default: return {31'd0, v[0]};
    endcase
  endfunction

  // Peripheral address for entry i: {0, param, type}.
  function automatic logic [7:0] entry_addr(input logic [3:0] i);
    logic [2:0] param;
    logic [3:0] typ;
    if (i < 4'd4)      param = 3'd0;
    else if (i < 4'd8) param = 3'd1;
    else               param = 3'd4;
    case (i[1:0])
      2'd0:    typ = 4'd0;
      2'd1:    typ = 4'd1;
      2'd2:    typ = 4'd4;
      default: typ = 4'd5;
    endcase
    return {1'b0, param, typ};
  endfunction

  assign next_addr   = entry_addr(idx + 4'd1);
  assign next_data   = entry_data(idx + 4'd1, n_q, m_q, c0_q);
  assign pll_ready_n = ready_sync[READY_SYNC_STAGES-1];

`ifdef RECONFIG_SEQ_VERIFY_EN
  logic [31:0] cur_data;
  assign cur_data = entry_data(idx, n_q, m_q, c0_q);
`endif

  // Bring the reconfigured domain's reset_n into this clock domain.
  always_ff @(posedge csi_clk_clock or negedge csi_clk_reset_n) begin
    if (!csi_clk_reset_n) ready_sync <= '0;
    else                  ready_sync <= {ready_sync[READY_SYNC_STAGES-2:0], pll_ready_n_async};
  end

  // Command sequencing FSM; every output is registered here.
  always_ff @(posedge csi_clk_clock or negedge csi_clk_reset_n) begin
    if (!csi_clk_reset_n) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      avm_address   <= 8'd0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      avm_writedata <= 32'd0;
      idx           <= 4'd0;
      n_q           <= 9'd0;
      m_q           <= 9'd0;
      c0_q          <= 9'd0;
      settle_cnt    <= 16'd0;
      tcnt          <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            n_q       <= cmd_n;
            m_q       <= cmd_m;
            c0_q      <= cmd_c0;
            idx       <= 4'd0;
            error     <= 1'b0;
            if (cmd_n == 9'd0 || cmd_m == 9'd0 || cmd_c0 == 9'd0) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              avm_write     <= 1'b1;
              avm_address   <= entry_addr(4'd0);
              avm_writedata <= entry_data(4'd0, cmd_n, cmd_m, cmd_c0);
              state         <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            if (idx == LAST_IDX) begin
`ifdef RECONFIG_SEQ_VERIFY_EN
              avm_write   <= 1'b0;
              avm_read    <= 1'b1;
              avm_address <= entry_addr(4'd0);
              idx         <= 4'd0;
              state       <= S_VERIFY;
`else
              avm_address   <= STATUS_ADDR;
              avm_writedata <= 32'd0;
              state         <= S_GO;
`endif
            end else begin
              idx           <= idx + 4'd1;
              avm_address   <= next_addr;
              avm_writedata <= next_data;
            end
          end
        end
`ifdef RECONFIG_SEQ_VERIFY_EN
        S_VERIFY: begin
          if (!avm_waitrequest) begin
            if (avm_readdata[8:0] != cur_data[8:0]) begin
              avm_read <= 1'b0;
              error    <= 1'b1;
              done     <= 1'b1;
              state    <= S_DONE;
            end else if (idx == LAST_IDX) begin
              avm_read      <= 1'b0;
              avm_write     <= 1'b1;
              avm_address   <= STATUS_ADDR;
              avm_writedata <= 32'd0;
              state         <= S_GO;
            end else begin
              idx         <= idx + 4'd1;
              avm_address <= next_addr;
            end
          end
        end
`endif
        S_GO: begin
          if (!avm_waitrequest) begin
            avm_write  <= 1'b0;
            settle_cnt <= 16'd0;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            avm_read    <= 1'b1;
            avm_address <= STATUS_ADDR;
            tcnt        <= 32'd0;
            state       <= S_POLL;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        S_POLL: begin
          tcnt <= tcnt + 32'd1;
          if (tcnt == TIMEOUT_LAST) begin
            avm_read <= 1'b0;
            error    <= 1'b1;
            done     <= 1'b1;
            state    <= S_DONE;
          end else if (!avm_waitrequest && avm_readdata == 32'd0) begin
            avm_read <= 1'b0;
            state    <= S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          tcnt <= tcnt + 32'd1;
          if (pll_ready_n) begin
            error <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (tcnt == TIMEOUT_LAST) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// tb/tb_pll_reconfig_sequencer.sv - directed self-checking bench for pll_reconfig_sequencer
module tb_pll_reconfig_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_n = 9'd0, cmd_m = 9'd0, cmd_c0 = 9'd0;
  logic        done, error;
  logic [7:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;
  logic        pll_ready_n_async = 1'b0;

  always #5 clk = ~clk;

  pll_reconfig_sequencer #(
    .SETTLE_CYCLES(4),
    .POLL_TIMEOUT(100),
    .READY_SYNC_STAGES(2)
  ) dut (
    .csi_clk_clock(clk),
    .csi_clk_reset_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_n(cmd_n),
    .cmd_m(cmd_m),
    .cmd_c0(cmd_c0),
    .done(done),
    .error(error),
    .avm_address(avm_address),
    .avm_write(avm_write),
    .avm_read(avm_read),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .pll_ready_n_async(pll_ready_n_async)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave model state
  int          cyc = 0;
  logic [31:0] mem [256];
  logic [7:0]  wlog_a [32];
  logic [31:0] wlog_d [32];
  int          wlog_n = 0;
  int          poll_reads = 0;
  int          other_reads = 0;
  int          busy_reads = 0;
  bit          poll_stuck = 0;
  bit          poll_zero = 0;
  bit          go_seen = 0;
  int          go_cyc = 0;
  int          first_poll_cyc = 0;
  int          both_cnt = 0;
  bit          stall_mode = 0;
  int          stall_left = 0;
  bit          in_xfer = 0;
  bit          stalled = 0;
  logic [41:0] held = '0;
  logic [7:0]  corrupt_addr = 8'hFF;
  int          done_cyc = 0;
  int          ready_bad = 0;
  logic [7:0]  exp_a [13];
  logic [31:0] exp_d [13];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_xfer = 0;
      stalled = 0;
      avm_waitrequest = 1'b0;
    end else begin
      if (avm_write && avm_read) both_cnt++;
      if (stalled)
        check_eq("stall_hold", {22'd0, avm_write, avm_read, avm_address, avm_writedata}, {22'd0, held});
      if (avm_write || avm_read) begin
        if (!in_xfer) begin
          in_xfer = 1;
          held = {avm_write, avm_read, avm_address, avm_writedata};
          stall_left = stall_mode ? int'($urandom_range(5, 0)) : 0;
          if (avm_read && avm_address == 8'h80 && poll_reads == 0) first_poll_cyc = cyc;
        end
        if (stall_left > 0) begin
          stall_left--;
          avm_waitrequest = 1'b1;
          stalled = 1;
        end else begin
          avm_waitrequest = 1'b0;
          stalled = 0;
          in_xfer = 0;
          if (avm_write) begin
            wlog_a[wlog_n] = avm_address;
            wlog_d[wlog_n] = avm_writedata;
            if (wlog_n < 31) wlog_n++;
            mem[avm_address] = avm_writedata;
            if (avm_address == 8'h80) begin
              go_seen = 1;
              go_cyc = cyc;
            end
          end else if (avm_address == 8'h80) begin
            if (poll_stuck || poll_reads < busy_reads) avm_readdata = 32'hFFFF_FFFF;
            else begin
              avm_readdata = 32'd0;
              poll_zero = 1;
            end
            poll_reads++;
          end else begin
            other_reads++;
            avm_readdata = mem[avm_address] ^ ((avm_address == corrupt_addr) ? 32'd1 : 32'd0);
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
        stalled = 0;
        in_xfer = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic clear_log();
    wlog_n = 0; poll_reads = 0; other_reads = 0; poll_zero = 0; go_seen = 0;
    both_cnt = 0; ready_bad = 0; first_poll_cyc = 0; go_cyc = 0;
  endtask

  task automatic start_cmd(input logic [8:0] n, input logic [8:0] m, input logic [8:0] c0);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_n = n; cmd_m = m; cmd_c0 = c0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output logic err);
    int t;
    t = 0;
    err = 1'bx;
    @(negedge clk);
    while (!done && t < 3000) begin
      if (cmd_ready) ready_bad++;
      @(negedge clk);
      t++;
    end
    check_eq("done_seen", done, 1);
    err = error;
    done_cyc = cyc;
    @(negedge clk);
    check_eq("done_pulse", done, 0);
    check_eq("ready_after", cmd_ready, 1);
    check_eq("ready_busy", ready_bad, 0);
    check_eq("rw_both", both_cnt, 0);
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_count"}, wlog_n, 13);
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("%s_addr[%0d]", tag, i), wlog_a[i], exp_a[i]);
      check_eq($sformatf("%s_data[%0d]", tag, i), wlog_d[i], exp_d[i]);
    end
  endtask

  initial begin
    logic err;
    int   t;
    int   late;
    exp_a = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h10, 8'h11, 8'h14, 8'h15,
              8'h40, 8'h41, 8'h44, 8'h45, 8'h80};
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", cmd_ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_strobes", {avm_write, avm_read}, 0);
    check_eq("rst_addr", avm_address, 0);
    check_eq("rst_wdata", avm_writedata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("ready_first", cmd_ready, 1);

    // n=1 m=4 c0=5, no stalls, pll held in reset until after the poll
    exp_d = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'd0,
              32'd3, 32'd2, 32'd0, 32'd1, 32'd0};
    clear_log();
    start_cmd(9'd1, 9'd4, 9'd5);
    t = 0;
    while (!poll_zero && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("poll_zero_seen", poll_zero, 1);
    late = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) late++;
    end
    check_eq("no_done_before_lock", late, 0);
    pll_ready_n_async = 1'b1;
    wait_done(err);
    check_eq("t1_error", err, 0);
    check_log("t1");
    check_eq("t1_polls", poll_reads, 1);
    check_eq("t1_settle_gap", first_poll_cyc - go_cyc, 5);

    // zero operand: immediate error, no bus traffic
    clear_log();
    start_cmd(9'd3, 9'd0, 9'd7);
    @(negedge clk);
    check_eq("bad_done", done, 1);
    check_eq("bad_error", error, 1);
    @(negedge clk);
    check_eq("bad_pulse", done, 0);
    check_eq("bad_err_hold", error, 1);
    check_eq("bad_writes", wlog_n, 0);
    check_eq("bad_reads", poll_reads + other_reads, 0);

    // random stalls, n=511 m=2 c0=3
    exp_d = '{32'd256, 32'd255, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0,
              32'd2, 32'd1, 32'd0, 32'd1, 32'd0};
    clear_log();
    stall_mode = 1;
    start_cmd(9'd511, 9'd2, 9'd3);
    wait_done(err);
    stall_mode = 0;
    check_eq("t3_error", err, 0);
    check_log("t3");

    // three busy polls then idle
    exp_d = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'd0,
              32'd3, 32'd2, 32'd0, 32'd1, 32'd0};
    clear_log();
    busy_reads = 3;
    start_cmd(9'd1, 9'd4, 9'd5);
    wait_done(err);
    busy_reads = 0;
    check_eq("t4_error", err, 0);
    check_eq("t4_polls", poll_reads, 4);
    check_eq("t4_settle_gap", first_poll_cyc - go_cyc, 5);

    // status stuck busy: timeout
    clear_log();
    poll_stuck = 1;
    start_cmd(9'd2, 9'd2, 9'd2);
    wait_done(err);
    poll_stuck = 0;
    check_eq("t5_error", err, 1);
    check_eq("t5_within", (done_cyc - first_poll_cyc) <= 100, 1);
    check_eq("t5_not_early", (done_cyc - first_poll_cyc) >= 90, 1);

    // reset during write index 6, then rerun from index 0
    clear_log();
    start_cmd(9'd1, 9'd4, 9'd5);
    t = 0;
    while (!(avm_write && avm_address == 8'h14) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("t6_reached_idx6", {avm_write, avm_address}, {1'b1, 8'h14});
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_strobes_drop", {avm_write, avm_read}, 0);
    check_eq("t6_ready_rst", cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1 check_eq("t6_no_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("t6_ready_after", cmd_ready, 1);
    clear_log();
    start_cmd(9'd1, 9'd4, 9'd5);
    wait_done(err);
    check_eq("t6_error", err, 0);
    check_log("t6");

`ifdef RECONFIG_SEQ_VERIFY_EN
    // corrupted readback of 0x14 aborts before the trigger write
    clear_log();
    corrupt_addr = 8'h14;
    start_cmd(9'd1, 9'd4, 9'd5);
    wait_done(err);
    corrupt_addr = 8'hFF;
    check_eq("t7_error", err, 1);
    check_eq("t7_no_go", go_seen, 0);
    check_eq("t7_writes", wlog_n, 12);
    check_eq("t7_reads", other_reads, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
